// File: rtl/stage_id_fwd.sv
// -----------------------------------------------------------------------------
// stage_id_fwd -- instruction decode stage of the MIPS-subset pipeline (IF -> ID -> EX)
//
// This stage holds the register file and decodes the incoming instruction. It
// resolves each source operand from the EX and MEM forwards, from a WB write in
// the same cycle, or from the register file. It inserts one bubble on a
// load-use hazard, and it registers a flattened ID->EX bundle.
//
// Ports:
//   clk, rst             rising-edge clock; asynchronous active-low reset
//   in_valid/in_instr/   instruction from IF and the PC of that instruction + 4
//   in_next_pc
//   stall, flush         hold the bundle / squash the current decode (flush wins)
//   reg_write_*          WB write port (address 0 = no write)
//   fwd_ex_*, fwd_mem_*  forwarding sources from EX and MEM
//   stall_req            combinational request to IF to hold its outputs
//   out_*                registered ID->EX bundle (1-cycle latency)
// -----------------------------------------------------------------------------
module stage_id_fwd #(
  parameter int DATA_WIDTH    = 32,
  parameter int REGADDR_WIDTH = 5,
  parameter int LINK_REG      = 31,
  localparam int ALU_OPT_WIDTH    = 6,
  localparam int MEM_OPT_WIDTH    = 2,
  localparam int BRANCH_OPT_WIDTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [31:0]                 in_instr,
  input  logic [DATA_WIDTH-1:0]       in_next_pc,
  input  logic                        stall,
  input  logic                        flush,
  input  logic [REGADDR_WIDTH-1:0]    reg_write_addr,
  input  logic [DATA_WIDTH-1:0]       reg_write_data,
  input  logic [REGADDR_WIDTH-1:0]    fwd_ex_addr,
  input  logic [DATA_WIDTH-1:0]       fwd_ex_data,
  input  logic                        fwd_ex_is_load,
  input  logic [REGADDR_WIDTH-1:0]    fwd_mem_addr,
  input  logic [DATA_WIDTH-1:0]       fwd_mem_data,
  output logic                        stall_req,
  output logic                        out_valid,
  output logic [ALU_OPT_WIDTH-1:0]    out_alu_opt,
  output logic                        out_alu_src,
  output logic [DATA_WIDTH-1:0]       out_sa_imm,
  output logic [DATA_WIDTH-1:0]       out_reg1_data,
  output logic [DATA_WIDTH-1:0]       out_reg2_data,
  output logic [REGADDR_WIDTH-1:0]    out_wb_addr,
  output logic [MEM_OPT_WIDTH-1:0]    out_mem_opt,
  output logic [BRANCH_OPT_WIDTH-1:0] out_branch_opt,
  output logic [DATA_WIDTH-1:0]       out_branch_dest,
  output logic [DATA_WIDTH-1:0]       out_pc,
  output logic                        out_illegal
);

  localparam int NUM_REGS = 1 << REGADDR_WIDTH;

  // ALU operation codes. R-type instructions pass their func field straight
  // through, so DISABLE and SETU use func values that no legal R-type uses.
  localparam logic [ALU_OPT_WIDTH-1:0] ALU_OPT_DISABLE = 6'h3F;
  localparam logic [ALU_OPT_WIDTH-1:0] ALU_OPT_SETU    = 6'h3E;
  localparam logic [ALU_OPT_WIDTH-1:0] ALU_OPT_ADDU    = 6'h21;
  localparam logic [ALU_OPT_WIDTH-1:0] ALU_OPT_SUBU    = 6'h23;
  localparam logic [ALU_OPT_WIDTH-1:0] ALU_OPT_AND     = 6'h24;
  localparam logic [ALU_OPT_WIDTH-1:0] ALU_OPT_OR      = 6'h25;
  localparam logic [ALU_OPT_WIDTH-1:0] ALU_OPT_XOR     = 6'h26;
  localparam logic [ALU_OPT_WIDTH-1:0] ALU_OPT_SLT     = 6'h2A;

  localparam logic ALU_SRC_REG = 1'b0;
  localparam logic ALU_SRC_IMM = 1'b1;

  localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_NONE = 2'd0;
  localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_LW   = 2'd1;
  localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_SW   = 2'd2;

  localparam logic [BRANCH_OPT_WIDTH-1:0] BRANCH_NONE       = 2'd0;
  localparam logic [BRANCH_OPT_WIDTH-1:0] BRANCH_UNCOND     = 2'd1;
  localparam logic [BRANCH_OPT_WIDTH-1:0] BRANCH_ON_ALU_EQZ = 2'd2;
  localparam logic [BRANCH_OPT_WIDTH-1:0] BRANCH_ON_ALU_NEZ = 2'd3;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [REGADDR_WIDTH-1:0] ZERO_ADDR = {REGADDR_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0]    ZERO_DATA = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0]    PC_STEP   = {{(DATA_WIDTH-3){1'b0}}, 3'd4};
  // Tells EX that the jump target is in reg2 and not in branch_dest.
  localparam logic [DATA_WIDTH-1:0]    DEST_REG_SENTINEL = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic                        valid;
    logic [ALU_OPT_WIDTH-1:0]    alu_opt;
    logic                        alu_src;
    logic [DATA_WIDTH-1:0]       sa_imm;
    logic [DATA_WIDTH-1:0]       reg1_data;
    logic [DATA_WIDTH-1:0]       reg2_data;
    logic [REGADDR_WIDTH-1:0]    wb_addr;
    logic [MEM_OPT_WIDTH-1:0]    mem_opt;
    logic [BRANCH_OPT_WIDTH-1:0] branch_opt;
    logic [DATA_WIDTH-1:0]       branch_dest;
    logic [DATA_WIDTH-1:0]       pc;
    logic                        illegal;
  } id_ex_t;

  // A bubble is an all-zero bundle in which every operation is NONE/DISABLE.
  function automatic id_ex_t bubble_f();
    id_ex_t b;
    b            = {$bits(id_ex_t){1'b0}};
    b.alu_opt    = ALU_OPT_DISABLE;
    b.alu_src    = ALU_SRC_REG;
    b.mem_opt    = MEM_OPT_NONE;
    b.branch_opt = BRANCH_NONE;
    return b;
  endfunction

  // Operand resolution. Address 0 always reads as 0. A load still in EX does
  // not forward, because its data is not yet valid.
  function automatic logic [DATA_WIDTH-1:0] operand_f(
    input logic [REGADDR_WIDTH-1:0] src,
    input logic [REGADDR_WIDTH-1:0] ex_addr,
    input logic [DATA_WIDTH-1:0]    ex_data,
    input logic                     ex_is_load,
    input logic [REGADDR_WIDTH-1:0] mem_addr,
    input logic [DATA_WIDTH-1:0]    mem_data,
    input logic [REGADDR_WIDTH-1:0] wb_addr,
    input logic [DATA_WIDTH-1:0]    wb_data,
    input logic [DATA_WIDTH-1:0]    rf_data
  );
    logic [DATA_WIDTH-1:0] val;
    if (src == ZERO_ADDR) begin
      val = ZERO_DATA;
    end else if ((ex_addr == src) && !ex_is_load) begin
      val = ex_data;
    end else if (mem_addr == src) begin
      val = mem_data;
    end else if (wb_addr == src) begin
      val = wb_data;
    end else begin
      val = rf_data;
    end
    return val;
  endfunction

  // Instruction fields
  logic [5:0]               opcode_s;
  logic [5:0]               func_s;
  logic [REGADDR_WIDTH-1:0] rs_s;
  logic [REGADDR_WIDTH-1:0] rt_s;
  logic [REGADDR_WIDTH-1:0] rd_s;
  logic [4:0]               sa_s;
  logic [15:0]              imm_s;
  logic [25:0]              target_s;

  assign opcode_s = in_instr[31:26];
  assign rs_s     = REGADDR_WIDTH'(in_instr[25:21]);
  assign rt_s     = REGADDR_WIDTH'(in_instr[20:16]);
  assign rd_s     = REGADDR_WIDTH'(in_instr[15:11]);
  assign sa_s     = in_instr[10:6];
  assign func_s   = in_instr[5:0];
  assign imm_s    = in_instr[15:0];
  assign target_s = in_instr[25:0];

  logic [DATA_WIDTH-1:0] pc_s;
  logic [DATA_WIDTH-1:0] link_s;
  logic [DATA_WIDTH-1:0] sext_s;
  logic [DATA_WIDTH-1:0] zext_s;
  logic [DATA_WIDTH-1:0] br_target_s;
  logic [DATA_WIDTH-1:0] j_target_s;

  assign pc_s        = in_next_pc - PC_STEP;
  // The return address skips the branch delay slot.
  assign link_s      = in_next_pc + PC_STEP;
  assign sext_s      = {{(DATA_WIDTH-16){imm_s[15]}}, imm_s};
  assign zext_s      = {{(DATA_WIDTH-16){1'b0}}, imm_s};
  assign br_target_s = in_next_pc + {{(DATA_WIDTH-18){imm_s[15]}}, imm_s, 2'b00};
  assign j_target_s  = {in_next_pc[DATA_WIDTH-1:28], target_s, 2'b00};

  // Register file
  logic [DATA_WIDTH-1:0] rf_q [0:NUM_REGS-1];

  // Register file write port; address 0 is never written, so entry 0 stays 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf_q[i] <= ZERO_DATA;
      end
    end else if (reg_write_addr != ZERO_ADDR) begin
      rf_q[reg_write_addr] <= reg_write_data;
    end
  end

  logic [DATA_WIDTH-1:0] rs_val_s;
  logic [DATA_WIDTH-1:0] rt_val_s;

  assign rs_val_s = operand_f(rs_s, fwd_ex_addr, fwd_ex_data, fwd_ex_is_load,
                              fwd_mem_addr, fwd_mem_data,
                              reg_write_addr, reg_write_data, rf_q[rs_s]);
  assign rt_val_s = operand_f(rt_s, fwd_ex_addr, fwd_ex_data, fwd_ex_is_load,
                              fwd_mem_addr, fwd_mem_data,
                              reg_write_addr, reg_write_data, rf_q[rt_s]);

  id_ex_t dec_s;
  logic   uses_rs_s;
  logic   uses_rt_s;
  logic   jr_fmt_s;
  logic   illegal_s;

  // Decoder: builds the bundle without operands and records which sources are read
  always_comb begin
    dec_s       = bubble_f();
    dec_s.valid = 1'b1;
    dec_s.pc    = pc_s;
    uses_rs_s   = 1'b0;
    uses_rt_s   = 1'b0;
    jr_fmt_s    = 1'b0;
    illegal_s   = 1'b0;
    case (opcode_s)
      OP_RTYPE: begin
        dec_s.wb_addr = rd_s;
        dec_s.alu_opt = func_s;
        dec_s.alu_src = ALU_SRC_REG;
        dec_s.sa_imm  = {{(DATA_WIDTH-5){1'b0}}, sa_s};
        uses_rs_s     = 1'b1;
        uses_rt_s     = 1'b1;
        case (func_s)
          // Constant shifts read only rt.
          FN_SLL, FN_SRL, FN_SRA: uses_rs_s = 1'b0;
          FN_SLLV, FN_SRLV, FN_SRAV, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
          FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: uses_rs_s = 1'b1;
          FN_JR: begin
            dec_s.wb_addr     = ZERO_ADDR;
            dec_s.alu_opt     = ALU_OPT_DISABLE;
            dec_s.sa_imm      = ZERO_DATA;
            dec_s.branch_opt  = BRANCH_UNCOND;
            dec_s.branch_dest = DEST_REG_SENTINEL;
            uses_rt_s         = 1'b0;
            jr_fmt_s          = 1'b1;
          end
          FN_JALR: begin
            dec_s.alu_opt     = ALU_OPT_SETU;
            dec_s.alu_src     = ALU_SRC_IMM;
            dec_s.sa_imm      = link_s;
            dec_s.branch_opt  = BRANCH_UNCOND;
            dec_s.branch_dest = DEST_REG_SENTINEL;
            uses_rt_s         = 1'b0;
            jr_fmt_s          = 1'b1;
          end
          default: illegal_s = 1'b1;
        endcase
      end
      OP_J: begin
        dec_s.branch_opt  = BRANCH_UNCOND;
        dec_s.branch_dest = j_target_s;
      end
      OP_JAL: begin
        dec_s.branch_opt  = BRANCH_UNCOND;
        dec_s.branch_dest = j_target_s;
        dec_s.wb_addr     = REGADDR_WIDTH'(LINK_REG);
        dec_s.alu_opt     = ALU_OPT_SETU;
        dec_s.alu_src     = ALU_SRC_IMM;
        dec_s.sa_imm      = link_s;
      end
      OP_BEQ, OP_BNE: begin
        dec_s.alu_opt     = ALU_OPT_SUBU;
        dec_s.alu_src     = ALU_SRC_REG;
        dec_s.branch_opt  = (opcode_s == OP_BEQ) ? BRANCH_ON_ALU_EQZ : BRANCH_ON_ALU_NEZ;
        dec_s.branch_dest = br_target_s;
        uses_rs_s         = 1'b1;
        uses_rt_s         = 1'b1;
      end
      OP_ADDIU, OP_SLTI, OP_LW: begin
        dec_s.alu_opt = (opcode_s == OP_SLTI) ? ALU_OPT_SLT : ALU_OPT_ADDU;
        dec_s.alu_src = ALU_SRC_IMM;
        dec_s.sa_imm  = sext_s;
        dec_s.wb_addr = rt_s;
        dec_s.mem_opt = (opcode_s == OP_LW) ? MEM_OPT_LW : MEM_OPT_NONE;
        uses_rs_s     = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        case (opcode_s)
          OP_ANDI: dec_s.alu_opt = ALU_OPT_AND;
          OP_ORI:  dec_s.alu_opt = ALU_OPT_OR;
          default: dec_s.alu_opt = ALU_OPT_XOR;
        endcase
        dec_s.alu_src = ALU_SRC_IMM;
        dec_s.sa_imm  = zext_s;
        dec_s.wb_addr = rt_s;
        uses_rs_s     = 1'b1;
      end
      OP_LUI: begin
        dec_s.alu_opt = ALU_OPT_SETU;
        dec_s.alu_src = ALU_SRC_IMM;
        dec_s.sa_imm  = {imm_s, {(DATA_WIDTH-16){1'b0}}};
        dec_s.wb_addr = rt_s;
      end
      OP_SW: begin
        dec_s.alu_opt = ALU_OPT_ADDU;
        dec_s.alu_src = ALU_SRC_IMM;
        dec_s.sa_imm  = sext_s;
        dec_s.mem_opt = MEM_OPT_SW;
        uses_rs_s     = 1'b1;
        uses_rt_s     = 1'b1;
      end
      default: illegal_s = 1'b1;
    endcase
    // An undecodable instruction goes on as a valid bubble that carries its PC,
    // so EX can raise the exception precisely.
    if (illegal_s) begin
      dec_s         = bubble_f();
      dec_s.valid   = 1'b1;
      dec_s.illegal = 1'b1;
      dec_s.pc      = pc_s;
      uses_rs_s     = 1'b0;
      uses_rt_s     = 1'b0;
      jr_fmt_s      = 1'b0;
    end else begin
      dec_s.illegal = 1'b0;
    end
  end

  // Load-use hazard: the instruction reads a register that a load in EX has not produced yet.
  logic hazard_s;
  assign hazard_s = in_valid && fwd_ex_is_load && (fwd_ex_addr != ZERO_ADDR) &&
                    ((uses_rs_s && (rs_s == fwd_ex_addr)) ||
                     (uses_rt_s && (rt_s == fwd_ex_addr)));
  assign stall_req = hazard_s && !stall && !flush;

  id_ex_t bundle_q;
  id_ex_t bundle_d;

  // Next-state bundle: flush, then stall, then hazard or no input, then decode
  always_comb begin
    bundle_d = bundle_q;
    if (flush) begin
      bundle_d = bubble_f();
    end else if (stall) begin
      bundle_d = bundle_q;
    end else if (hazard_s || !in_valid) begin
      bundle_d = bubble_f();
    end else begin
      bundle_d           = dec_s;
      bundle_d.reg1_data = uses_rs_s ? rs_val_s : ZERO_DATA;
      // Register jumps send their target to EX in reg2.
      bundle_d.reg2_data = jr_fmt_s ? rs_val_s : (uses_rt_s ? rt_val_s : ZERO_DATA);
    end
  end

  // ID->EX bundle register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bundle_q <= bubble_f();
    end else begin
      bundle_q <= bundle_d;
    end
  end

  assign out_valid       = bundle_q.valid;
  assign out_alu_opt     = bundle_q.alu_opt;
  assign out_alu_src     = bundle_q.alu_src;
  assign out_sa_imm      = bundle_q.sa_imm;
  assign out_reg1_data   = bundle_q.reg1_data;
  assign out_reg2_data   = bundle_q.reg2_data;
  assign out_wb_addr     = bundle_q.wb_addr;
  assign out_mem_opt     = bundle_q.mem_opt;
  assign out_branch_opt  = bundle_q.branch_opt;
  assign out_branch_dest = bundle_q.branch_dest;
  assign out_pc          = bundle_q.pc;
  assign out_illegal     = bundle_q.illegal;

endmodule

// File: tb/tb_stage_id_fwd.sv
// -----------------------------------------------------------------------------
// tb_stage_id_fwd -- directed, self-checking bench for stage_id_fwd.
// Each step drives one instruction and pushes the bundle it should produce.
// One cycle later the bench pops that bundle and compares it field by field.
// -----------------------------------------------------------------------------
module tb_stage_id_fwd;

  localparam logic [5:0] ALU_DISABLE = 6'h3F;
  localparam logic [5:0] ALU_SETU    = 6'h3E;
  localparam logic [5:0] ALU_ADDU    = 6'h21;
  localparam logic [5:0] ALU_SUBU    = 6'h23;
  localparam logic [1:0] MEM_NONE    = 2'd0;
  localparam logic [1:0] MEM_SW      = 2'd2;
  localparam logic [1:0] BR_NONE     = 2'd0;
  localparam logic [1:0] BR_UNCOND   = 2'd1;
  localparam logic [1:0] BR_NEZ      = 2'd3;

  typedef struct {
    logic        valid;
    logic [5:0]  alu;
    logic        src;
    logic [31:0] sa_imm;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  wb;
    logic [1:0]  mem;
    logic [1:0]  br;
    logic [31:0] dest;
    logic [31:0] pc;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_next_pc;
  logic        stall;
  logic        flush;
  logic [4:0]  reg_write_addr;
  logic [31:0] reg_write_data;
  logic [4:0]  fwd_ex_addr;
  logic [31:0] fwd_ex_data;
  logic        fwd_ex_is_load;
  logic [4:0]  fwd_mem_addr;
  logic [31:0] fwd_mem_data;
  logic        stall_req;
  logic        out_valid;
  logic [5:0]  out_alu_opt;
  logic        out_alu_src;
  logic [31:0] out_sa_imm;
  logic [31:0] out_reg1_data;
  logic [31:0] out_reg2_data;
  logic [4:0]  out_wb_addr;
  logic [1:0]  out_mem_opt;
  logic [1:0]  out_branch_opt;
  logic [31:0] out_branch_dest;
  logic [31:0] out_pc;
  logic        out_illegal;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  exp_t e_bne;

  stage_id_fwd dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_next_pc(in_next_pc),
    .stall(stall), .flush(flush),
    .reg_write_addr(reg_write_addr), .reg_write_data(reg_write_data),
    .fwd_ex_addr(fwd_ex_addr), .fwd_ex_data(fwd_ex_data), .fwd_ex_is_load(fwd_ex_is_load),
    .fwd_mem_addr(fwd_mem_addr), .fwd_mem_data(fwd_mem_data),
    .stall_req(stall_req), .out_valid(out_valid), .out_alu_opt(out_alu_opt),
    .out_alu_src(out_alu_src), .out_sa_imm(out_sa_imm), .out_reg1_data(out_reg1_data),
    .out_reg2_data(out_reg2_data), .out_wb_addr(out_wb_addr), .out_mem_opt(out_mem_opt),
    .out_branch_opt(out_branch_opt), .out_branch_dest(out_branch_dest), .out_pc(out_pc),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  function automatic exp_t bub();
    exp_t e;
    e = '{valid: 1'b0, alu: ALU_DISABLE, src: 1'b0, sa_imm: 32'h0, r1: 32'h0, r2: 32'h0,
          wb: 5'd0, mem: MEM_NONE, br: BR_NONE, dest: 32'h0, pc: 32'h0, ill: 1'b0};
    return e;
  endfunction

  function automatic exp_t ins(input logic [5:0] alu, input logic src, input logic [31:0] sa_imm,
                               input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] wb,
                               input logic [1:0] mem, input logic [1:0] br,
                               input logic [31:0] dest, input logic [31:0] pc);
    exp_t e;
    e = '{valid: 1'b1, alu: alu, src: src, sa_imm: sa_imm, r1: r1, r2: r2,
          wb: wb, mem: mem, br: br, dest: dest, pc: pc, ill: 1'b0};
    return e;
  endfunction

  function automatic exp_t illegal_at(input logic [31:0] pc);
    exp_t e;
    e       = bub();
    e.valid = 1'b1;
    e.ill   = 1'b1;
    e.pc    = pc;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bundle(input string step, input exp_t e);
    chk({step, ".valid"},  32'(out_valid),       32'(e.valid));
    chk({step, ".alu"},    32'(out_alu_opt),     32'(e.alu));
    chk({step, ".src"},    32'(out_alu_src),     32'(e.src));
    chk({step, ".sa_imm"}, out_sa_imm,           e.sa_imm);
    chk({step, ".reg1"},   out_reg1_data,        e.r1);
    chk({step, ".reg2"},   out_reg2_data,        e.r2);
    chk({step, ".wb"},     32'(out_wb_addr),     32'(e.wb));
    chk({step, ".mem"},    32'(out_mem_opt),     32'(e.mem));
    chk({step, ".br"},     32'(out_branch_opt),  32'(e.br));
    chk({step, ".dest"},   out_branch_dest,      e.dest);
    chk({step, ".pc"},     out_pc,               e.pc);
    chk({step, ".ill"},    32'(out_illegal),     32'(e.ill));
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] npc);
    in_valid   = v;
    in_instr   = instr;
    in_next_pc = npc;
  endtask

  task automatic chk_req(input string step, input logic exp);
    #1;
    chk({step, ".stall_req"}, 32'(stall_req), 32'(exp));
  endtask

  // Push the expectation, let one edge pass, then pop it and compare on the falling edge.
  task automatic expect_out(input string step, input exp_t e);
    exp_t got;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      chk({step, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      check_bundle(step, got);
    end
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    reg_write_addr = 5'd0; reg_write_data = 32'h0;
    fwd_ex_addr = 5'd0; fwd_ex_data = 32'h0; fwd_ex_is_load = 1'b0;
    fwd_mem_addr = 5'd0; fwd_mem_data = 32'h0;

    @(negedge clk);
    check_bundle("reset", bub());
    rst = 1'b1;

    // ADDIU $1,$0,0x8000
    drive(1'b1, 32'h24018000, 32'h00400004);
    chk_req("addiu", 1'b0);
    expect_out("addiu", ins(ALU_ADDU, 1'b1, 32'hFFFF8000, 32'h0, 32'h0, 5'd1,
                            MEM_NONE, BR_NONE, 32'h0, 32'h00400000));

    // Asynchronous reset in the middle of a cycle clears the outputs at once
    #2 rst = 1'b0;
    #1 check_bundle("midrst", bub());
    @(negedge clk);
    rst = 1'b1;

    // Write $2=0x1234 through WB while IF is idle, then read it from the register file
    drive(1'b0, 32'h0, 32'h0);
    reg_write_addr = 5'd2; reg_write_data = 32'h00001234;
    expect_out("idle", bub());
    reg_write_addr = 5'd0;
    drive(1'b1, 32'h00421821, 32'h00000104);   // ADDU $3,$2,$2
    expect_out("rf_read", ins(ALU_ADDU, 1'b0, 32'h0, 32'h1234, 32'h1234, 5'd3,
                              MEM_NONE, BR_NONE, 32'h0, 32'h100));

    // Same-cycle WB bypass
    reg_write_addr = 5'd2; reg_write_data = 32'h00000077;
    expect_out("wb_bypass", ins(ALU_ADDU, 1'b0, 32'h0, 32'h77, 32'h77, 5'd3,
                                MEM_NONE, BR_NONE, 32'h0, 32'h100));
    reg_write_addr = 5'd0; reg_write_data = 32'h0;

    // EX and MEM both forward $2: EX has priority
    fwd_ex_addr = 5'd2; fwd_ex_data = 32'h55;
    fwd_mem_addr = 5'd2; fwd_mem_data = 32'h66;
    expect_out("ex_over_mem", ins(ALU_ADDU, 1'b0, 32'h0, 32'h55, 32'h55, 5'd3,
                                  MEM_NONE, BR_NONE, 32'h0, 32'h100));
    fwd_ex_addr = 5'd0; fwd_ex_data = 32'hFF;
    expect_out("mem_fwd", ins(ALU_ADDU, 1'b0, 32'h0, 32'h66, 32'h66, 5'd3,
                              MEM_NONE, BR_NONE, 32'h0, 32'h100));

    // Forwarding address 0 must never reach a read of $0
    fwd_mem_addr = 5'd0; fwd_mem_data = 32'hFF;
    reg_write_addr = 5'd0; reg_write_data = 32'hFF;
    drive(1'b1, 32'h00001821, 32'h00000104);   // ADDU $3,$0,$0
    expect_out("zero_reg", ins(ALU_ADDU, 1'b0, 32'h0, 32'h0, 32'h0, 5'd3,
                               MEM_NONE, BR_NONE, 32'h0, 32'h100));
    reg_write_data = 32'h0;

    // Load-use: LW $4 in EX, then SW $4,0($5) -> one bubble, then the MEM forward
    fwd_ex_is_load = 1'b1; fwd_ex_addr = 5'd4; fwd_ex_data = 32'hBAD;
    drive(1'b1, 32'hACA40000, 32'h00000200);
    chk_req("loaduse", 1'b1);
    expect_out("loaduse_bubble", bub());
    fwd_ex_is_load = 1'b0; fwd_ex_addr = 5'd0;
    fwd_mem_addr = 5'd4; fwd_mem_data = 32'h0000DEAD;
    chk_req("loaduse_after", 1'b0);
    expect_out("sw_after", ins(ALU_ADDU, 1'b1, 32'h0, 32'h0, 32'hDEAD, 5'd0,
                               MEM_SW, BR_NONE, 32'h0, 32'h1FC));

    // LUI does not read rt, so a load to $4 in EX must not stall it
    fwd_ex_is_load = 1'b1; fwd_ex_addr = 5'd4;
    drive(1'b1, 32'h3C041234, 32'h00000204);
    chk_req("lui", 1'b0);
    expect_out("lui", ins(ALU_SETU, 1'b1, 32'h12340000, 32'h0, 32'h0, 5'd4,
                          MEM_NONE, BR_NONE, 32'h0, 32'h200));
    fwd_ex_is_load = 1'b0; fwd_ex_addr = 5'd0; fwd_mem_addr = 5'd0;

    // JAL at pc 0x00400010, target field 0x0100000
    drive(1'b1, 32'h0C100000, 32'h00400014);
    expect_out("jal", ins(ALU_SETU, 1'b1, 32'h00400018, 32'h0, 32'h0, 5'd31,
                          MEM_NONE, BR_UNCOND, 32'h00400000, 32'h00400010));

    // BNE $1,$2,-1 at next_pc 0: the target wraps
    drive(1'b1, 32'h1422FFFF, 32'h00000000);
    e_bne = ins(ALU_SUBU, 1'b0, 32'h0, 32'h0, 32'h77, 5'd0,
                MEM_NONE, BR_NEZ, 32'hFFFFFFFC, 32'hFFFFFFFC);
    expect_out("bne", e_bne);

    // Stall holds the bundle and suppresses stall_req, even with a load-use hazard present
    stall = 1'b1;
    fwd_ex_is_load = 1'b1; fwd_ex_addr = 5'd2;
    drive(1'b1, 32'h00421821, 32'h00000400);
    chk_req("stall", 1'b0);
    expect_out("stall_hold", e_bne);

    // Flush together with stall loads a bubble
    flush = 1'b1;
    chk_req("flush_stall", 1'b0);
    expect_out("flush_stall", bub());
    stall = 1'b0; flush = 1'b0;
    fwd_ex_is_load = 1'b0; fwd_ex_addr = 5'd0;

    // Illegal opcode and illegal R-type func
    drive(1'b1, 32'hFC000000, 32'h00000300);
    expect_out("ill_op", illegal_at(32'h2FC));
    drive(1'b1, 32'h0000003F, 32'h00000304);
    expect_out("ill_fn", illegal_at(32'h300));

    // JR $2: register target in reg2, sentinel destination
    drive(1'b1, 32'h00400008, 32'h00000308);
    expect_out("jr", ins(ALU_DISABLE, 1'b0, 32'h0, 32'h77, 32'h77, 5'd0,
                         MEM_NONE, BR_UNCOND, 32'h1, 32'h304));

    // No instruction presented -> bubble
    drive(1'b0, 32'h00421821, 32'h00000400);
    expect_out("no_valid", bub());

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
